// File: rtl/egress_rr_unloader_pkg.sv
// Shared encodings for the egress round-robin unloader and the arbiters built on it.
package egress_rr_unloader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      CAP  = 2'd2,
      SEND = 2'd3
   } state_t;

   localparam logic EG0 = 1'b0;
   localparam logic EG1 = 1'b1;

endpackage

// File: rtl/egress_rr_unloader_rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is chosen.
module rr_arbiter2
   import egress_rr_unloader_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_sel
);

   // Grant decode from the two requests and the previous winner
   always_comb begin
      gnt_valid = req0 | req1;
      gnt_sel   = EG0;
      if (req0 && req1) begin
         gnt_sel = ~last_grant;
      end else if (req1) begin
         gnt_sel = EG1;
      end else begin
         gnt_sel = EG0;
      end
   end

endmodule

// File: rtl/egress_rr_unloader.sv
// Unloads the two egress FIFOs one word at a time in round-robin order onto a
// single valid/ready stream tagged with the source egress, counting delivered words.
module egress_rr_unloader
   import egress_rr_unloader_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  fifo_empty_e0,
   input  logic                  fifo_empty_e1,
   input  logic [DATA_WIDTH-1:0] data_e0,
   input  logic [DATA_WIDTH-1:0] data_e1,
   output logic                  pop_e0,
   output logic                  pop_e1,
   input  logic                  ready_out,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  dest_out,
   output logic [CNT_WIDTH-1:0]  count_e0,
   output logic [CNT_WIDTH-1:0]  count_e1,
   output logic                  idle
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t state_r;
   logic   sel_r;
   logic   last_grant_r;
   logic   req0_s;
   logic   req1_s;
   logic   gnt_valid_s;
   logic   gnt_sel_s;

   // Empty flags only matter while IDLE; the FSM ignores the grant elsewhere
   always_comb begin
      req0_s = ~fifo_empty_e0;
      req1_s = ~fifo_empty_e1;
   end

   rr_arbiter2 u_arb (
      .req0       (req0_s),
      .req1       (req1_s),
      .last_grant (last_grant_r),
      .gnt_valid  (gnt_valid_s),
      .gnt_sel    (gnt_sel_s)
   );

   // Unload FSM; every output is registered alongside the state it belongs to
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         sel_r        <= EG0;
         last_grant_r <= EG1;
         pop_e0       <= 1'b0;
         pop_e1       <= 1'b0;
         valid_out    <= 1'b0;
         data_out     <= {DATA_WIDTH{1'b0}};
         dest_out     <= EG0;
         count_e0     <= {CNT_WIDTH{1'b0}};
         count_e1     <= {CNT_WIDTH{1'b0}};
         idle         <= 1'b1;
      end else begin
         pop_e0 <= 1'b0;
         pop_e1 <= 1'b0;
         case (state_r)
            IDLE: begin
               if (enable && gnt_valid_s) begin
                  sel_r   <= gnt_sel_s;
                  pop_e0  <= (gnt_sel_s == EG0);
                  pop_e1  <= (gnt_sel_s == EG1);
                  idle    <= 1'b0;
                  state_r <= POP;
               end else begin
                  idle    <= 1'b1;
               end
            end
            POP: begin
               state_r <= CAP;
            end
            CAP: begin
               data_out  <= (sel_r == EG1) ? data_e1 : data_e0;
               dest_out  <= sel_r;
               valid_out <= 1'b1;
               state_r   <= SEND;
            end
            SEND: begin
               if (ready_out) begin
                  if (sel_r == EG1) begin
                     count_e1 <= count_e1 + CNT_ONE;
                  end else begin
                     count_e0 <= count_e0 + CNT_ONE;
                  end
                  last_grant_r <= sel_r;
                  valid_out    <= 1'b0;
                  idle         <= 1'b1;
                  state_r      <= IDLE;
               end else begin
                  valid_out    <= 1'b1;
               end
            end
            default: begin
               valid_out <= 1'b0;
               idle      <= 1'b1;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_egress_rr_unloader.sv
// Scoreboard bench for egress_rr_unloader: queue-based FIFO models feed the DUT,
// a rule-level planner predicts the delivered stream, a monitor checks handshakes.
module tb_egress_rr_unloader;

   localparam int DW = 8;
   localparam int CW = 8;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          dest;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          fifo_empty_e0;
   logic          fifo_empty_e1;
   logic [DW-1:0] data_e0;
   logic [DW-1:0] data_e1;
   logic          pop_e0;
   logic          pop_e1;
   logic          ready_out;
   logic          valid_out;
   logic [DW-1:0] data_out;
   logic          dest_out;
   logic [CW-1:0] count_e0;
   logic [CW-1:0] count_e1;
   logic          idle;

   logic [DW-1:0] e0_q[$];
   logic [DW-1:0] e1_q[$];
   exp_t          exp_q[$];
   logic          plan_lg;
   logic [CW-1:0] mdl_cnt0;
   logic [CW-1:0] mdl_cnt1;
   int            rdy_mode;
   bit            chk_gap;
   int            pop_cnt;
   int            n_tests;
   int            n_fail;

   egress_rr_unloader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .fifo_empty_e0 (fifo_empty_e0),
      .fifo_empty_e1 (fifo_empty_e1),
      .data_e0       (data_e0),
      .data_e1       (data_e1),
      .pop_e0        (pop_e0),
      .pop_e1        (pop_e1),
      .ready_out     (ready_out),
      .valid_out     (valid_out),
      .data_out      (data_out),
      .dest_out      (dest_out),
      .count_e0      (count_e0),
      .count_e1      (count_e1),
      .idle          (idle)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: FIFO read model reacts to the registered pop, then ready is driven
   task automatic step();
      @(posedge clk);
      #1;
      if (pop_e0 === 1'b1 || pop_e1 === 1'b1) chk("pops_exclusive", 32'(pop_e0 & pop_e1), 32'd0);
      if (pop_e0 === 1'b1) begin
         pop_cnt++;
         chk("pop_e0_nonempty", 32'(e0_q.size() != 0), 32'd1);
         if (e0_q.size() != 0) data_e0 = e0_q.pop_front();
      end
      if (pop_e1 === 1'b1) begin
         pop_cnt++;
         chk("pop_e1_nonempty", 32'(e1_q.size() != 0), 32'd1);
         if (e1_q.size() != 0) data_e1 = e1_q.pop_front();
      end
      fifo_empty_e0 = (e0_q.size() == 0);
      fifo_empty_e1 = (e1_q.size() == 0);
      case (rdy_mode)
         0: ready_out = 1'b0;
         1: ready_out = 1'b1;
         default: ready_out = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic load0(input logic [DW-1:0] d);
      e0_q.push_back(d);
      fifo_empty_e0 = 1'b0;
   endtask

   task automatic load1(input logic [DW-1:0] d);
      e1_q.push_back(d);
      fifo_empty_e1 = 1'b0;
   endtask

   // Predict the next n deliveries (n<0: everything queued) from the round-robin rule
   task automatic plan(input int n);
      logic [DW-1:0] a[$];
      logic [DW-1:0] b[$];
      exp_t e;
      int   k;
      a = e0_q;
      b = e1_q;
      k = 0;
      while ((a.size() > 0 || b.size() > 0) && (n < 0 || k < n)) begin
         if (a.size() > 0 && b.size() > 0) e.dest = ~plan_lg;
         else if (a.size() > 0)            e.dest = 1'b0;
         else                              e.dest = 1'b1;
         e.d = e.dest ? b.pop_front() : a.pop_front();
         exp_q.push_back(e);
         plan_lg = e.dest;
         k++;
      end
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      step();
      reset = 1'b0;
      plan_lg = 1'b1;
   endtask

   task automatic drain(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && idle === 1'b1 && valid_out === 1'b0) begin
            done = 1'b1;
            break;
         end
         step();
      end
      chk("drain_timeout", 32'(done), 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (valid_out === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("valid_timeout", 32'(seen), 32'd1);
   endtask

   // Monitor: checks every handshake against the scoreboard and holds under backpressure
   initial begin
      int            cyc;
      int            prev_cyc;
      bit            have_prev;
      bit            prev_hold;
      logic [DW-1:0] hold_d;
      logic          hold_dest;
      exp_t          e;
      cyc = 0;
      prev_cyc = 0;
      have_prev = 1'b0;
      prev_hold = 1'b0;
      hold_d = '0;
      hold_dest = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset === 1'b1) begin
            exp_q.delete();
            mdl_cnt0 = '0;
            mdl_cnt1 = '0;
            have_prev = 1'b0;
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               chk("hold_valid", 32'(valid_out), 32'd1);
               chk("hold_data", 32'(data_out), 32'(hold_d));
               chk("hold_dest", 32'(dest_out), 32'(hold_dest));
            end
            if (valid_out === 1'b1 && ready_out === 1'b1) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("data_out", 32'(data_out), 32'(e.d));
                  chk("dest_out", 32'(dest_out), 32'(e.dest));
                  chk("count_e0_pre", 32'(count_e0), 32'(mdl_cnt0));
                  chk("count_e1_pre", 32'(count_e1), 32'(mdl_cnt1));
                  if (e.dest) mdl_cnt1 = mdl_cnt1 + 1'b1;
                  else        mdl_cnt0 = mdl_cnt0 + 1'b1;
                  if (chk_gap && have_prev) chk("word_spacing", 32'(cyc - prev_cyc), 32'd4);
                  have_prev = 1'b1;
                  prev_cyc = cyc;
               end
               prev_hold = 1'b0;
            end else if (valid_out === 1'b1) begin
               prev_hold = 1'b1;
               hold_d = data_out;
               hold_dest = dest_out;
            end else begin
               prev_hold = 1'b0;
            end
            if (!chk_gap) have_prev = 1'b0;
         end
      end
   end

   initial begin
      int pc;
      int n0;
      int n1;
      n_tests = 0;
      n_fail = 0;
      pop_cnt = 0;
      reset = 1'b1;
      enable = 1'b0;
      rdy_mode = 1;
      ready_out = 1'b0;
      data_e0 = '0;
      data_e1 = '0;
      fifo_empty_e0 = 1'b1;
      fifo_empty_e1 = 1'b1;
      chk_gap = 1'b0;
      plan_lg = 1'b1;
      mdl_cnt0 = '0;
      mdl_cnt1 = '0;

      // Reset held with both FIFOs non-empty and enable high
      load0(8'h11);
      load1(8'h12);
      enable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_pop_e0", 32'(pop_e0), 32'd0);
         chk("rst_pop_e1", 32'(pop_e1), 32'd0);
         chk("rst_valid", 32'(valid_out), 32'd0);
         chk("rst_count_e0", 32'(count_e0), 32'd0);
         chk("rst_count_e1", 32'(count_e1), 32'd0);
         chk("rst_idle", 32'(idle), 32'd1);
      end
      enable = 1'b0;
      reset = 1'b0;
      e0_q.delete();
      e1_q.delete();
      fifo_empty_e0 = 1'b1;
      fifo_empty_e1 = 1'b1;
      step();

      // Single FIFO stream with latency check
      load0(8'hAB); load0(8'hAC); load0(8'hAD);
      plan(-1);
      chk_gap = 1'b1;
      step();
      enable = 1'b1;
      step();
      chk("lat_pop", 32'(pop_e0), 32'd1);
      step();
      step();
      chk("lat_valid", 32'(valid_out), 32'd1);
      drain(100);
      chk("single_count_e0", 32'(count_e0), 32'd3);
      chk("single_count_e1", 32'(count_e1), 32'd0);

      // Round-robin alternation from a fresh reset
      reset_pulse();
      load0(8'hFF); load0(8'hFA);
      load1(8'hBB); load1(8'hAA);
      plan(-1);
      drain(100);
      chk("rr_count_e0", 32'(count_e0), 32'd2);
      chk("rr_count_e1", 32'(count_e1), 32'd2);
      chk_gap = 1'b0;

      // Backpressure on a single E1 word
      reset_pulse();
      rdy_mode = 0;
      pc = pop_cnt;
      load1(8'hCC);
      plan(-1);
      wait_valid(20);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_valid", 32'(valid_out), 32'd1);
         chk("bp_data", 32'(data_out), 32'hCC);
         chk("bp_count_e1", 32'(count_e1), 32'd0);
      end
      rdy_mode = 1;
      drain(50);
      chk("bp_pops", 32'(pop_cnt - pc), 32'd1);
      chk("bp_count_e1_after", 32'(count_e1), 32'd1);

      // Enable dropped while the word sits in CAP
      reset_pulse();
      enable = 1'b0;
      load0(8'h31); load0(8'h32);
      plan(1);
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (pop_e0 === 1'b1) break;
      end
      step();
      enable = 1'b0;
      drain(50);
      pc = pop_cnt;
      repeat (10) step();
      chk("en_no_pop", 32'(pop_cnt - pc), 32'd0);
      chk("en_idle", 32'(idle), 32'd1);
      chk("en_left", 32'(e0_q.size()), 32'd1);
      chk("en_count_e0", 32'(count_e0), 32'd1);
      e0_q.delete();
      fifo_empty_e0 = 1'b1;

      // Reset while 0xDA is held in SEND after E0 won the previous grant
      reset_pulse();
      enable = 1'b1;
      load0(8'h41);
      plan(-1);
      drain(50);
      rdy_mode = 0;
      load1(8'hDA);
      wait_valid(20);
      chk("held_da", 32'(data_out), 32'hDA);
      reset = 1'b1;
      step();
      reset = 1'b0;
      plan_lg = 1'b1;
      chk("mid_rst_valid", 32'(valid_out), 32'd0);
      chk("mid_rst_count_e0", 32'(count_e0), 32'd0);
      chk("mid_rst_count_e1", 32'(count_e1), 32'd0);
      load0(8'h51);
      load1(8'h52);
      rdy_mode = 1;
      plan(-1);
      drain(50);
      chk("post_rst_count_e0", 32'(count_e0), 32'd1);
      chk("post_rst_count_e1", 32'(count_e1), 32'd1);

      // Randomized bursts with random backpressure
      for (int r = 0; r < 8; r++) begin
         rdy_mode = 2;
         n0 = $urandom_range(0, 6);
         n1 = $urandom_range(0, 6);
         for (int i = 0; i < n0; i++) load0(8'($urandom));
         for (int i = 0; i < n1; i++) load1(8'($urandom));
         plan(-1);
         drain(40 * (n0 + n1) + 50);
         chk("rand_count_e0", 32'(count_e0), 32'(mdl_cnt0));
         chk("rand_count_e1", 32'(count_e1), 32'(mdl_cnt1));
      end

      // Counter wrap on the E0 counter
      reset_pulse();
      rdy_mode = 1;
      for (int i = 0; i < (1 << CW) - 1; i++) load0(8'($urandom));
      plan(-1);
      drain(5 * (1 << CW) + 50);
      chk("wrap_max", 32'(count_e0), 32'((1 << CW) - 1));
      load0(8'h5A);
      plan(-1);
      drain(50);
      chk("wrap_zero", 32'(count_e0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
